stage_f: RTL and testbench

Instruction fetch stage of the Polaris pipeline, feeding `stage_d`. Maintains the 64-bit program counter and fetches 32-bit instructions over a Wishbone classic instruction bus. Each fetched word is presented to the decode stage for exactly one cycle, with `f_ack_o` asserted. Cycles with no valid instruction present a bubble (`ADDI X0,X0,0`). Redirects from the execute stage squash in-flight or coincident fetches.

---
 rtl/polaris_pkg.sv | 16 +
 rtl/stage_f_if.sv | 37 +++
 rtl/stage_f.sv | 154 +++++++++++++++
 tb/tb_stage_f.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polaris_pkg.sv
// Shared Polaris pipeline definitions: data width, the canonical bubble
// instruction and the fetch-stage state encoding.
package polaris_pkg;

    localparam int XLEN = 64;

    // ADDI X0,X0,0 -- what decode sees whenever fetch has nothing to offer.
    localparam logic [31:0] INSN_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SQUASH
    } fetch_state_e;

endpackage

// File: rtl/stage_f_if.sv
// Wishbone classic instruction bus between stage_f (master) and memory
// (slave). The bus error line exists only when POLARIS_FETCH_ERR_EN is defined.
interface stage_f_if;
    import polaris_pkg::*;

    logic [XLEN-1:0] i_adr_o;
    logic            i_cyc_o;
    logic            i_stb_o;
    logic            i_ack_i;
    logic [31:0]     i_dat_i;
`ifdef POLARIS_FETCH_ERR_EN
    logic            i_err_i;
`endif

`ifdef POLARIS_FETCH_ERR_EN
    modport master (
        output i_adr_o, i_cyc_o, i_stb_o,
        input  i_ack_i, i_dat_i, i_err_i
    );

    modport slave (
        input  i_adr_o, i_cyc_o, i_stb_o,
        output i_ack_i, i_dat_i, i_err_i
    );
`else
    modport master (
        output i_adr_o, i_cyc_o, i_stb_o,
        input  i_ack_i, i_dat_i
    );

    modport slave (
        input  i_adr_o, i_cyc_o, i_stb_o,
        output i_ack_i, i_dat_i
    );
`endif

endinterface

// File: rtl/stage_f.sv
// Polaris instruction fetch stage. Holds the program counter, runs one
// Wishbone classic read at a time and hands each accepted word to decode as
// a single-cycle pulse. Redirects from execute squash the word in flight.
// Optional feature: POLARIS_FETCH_ERR_EN adds i_err_i/f_err_o; a bus error
// is reported to decode and fetch parks in IDLE until the next redirect.
module stage_f
    import polaris_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    stage_f_if.master       bus,
    output logic            f_ack_o,
    output logic [31:0]     f_dat_o,
    output logic [XLEN-1:0] f_pc_o,
`ifdef POLARIS_FETCH_ERR_EN
    output logic            f_err_o,
`endif
    input  logic            x_jump_i,
    input  logic [XLEN-1:0] x_target_i
);

    fetch_state_e    state;
    fetch_state_e    next_state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] jump_tgt;
    logic            bus_err;
    logic            bus_done;
    logic            halted;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign jump_tgt = x_target_i & ~XLEN'(3);

`ifdef POLARIS_FETCH_ERR_EN
    assign bus_err = bus.i_err_i;
`else
    assign bus_err = 1'b0;
    assign halted  = 1'b0;
`endif

    // An error ends a bus cycle exactly like an acknowledge does.
    assign bus_done = bus.i_ack_i | bus_err;

    // State register; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a jump without an ack must wait out the bus cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!halted || x_jump_i) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (bus_done) begin
                    if (bus_err && !x_jump_i) begin
                        next_state = IDLE;
                    end
                end else if (x_jump_i) begin
                    next_state = SQUASH;
                end
            end
            SQUASH: begin
                if (bus_done) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs depend only on registered state, never on the ack input.
    always_comb begin
        bus.i_cyc_o = (state != IDLE);
        bus.i_stb_o = (state != IDLE);
        bus.i_adr_o = pc;
    end

    // PC, pending redirect and registered decode-side outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc      <= RESET_PC;
            pend    <= '0;
            f_ack_o <= 1'b0;
            f_dat_o <= INSN_NOP;
            f_pc_o  <= '0;
        end else begin
            f_ack_o <= 1'b0;
            f_dat_o <= INSN_NOP;
            unique case (state)
                IDLE: begin
                    if (halted && x_jump_i) begin
                        pc <= jump_tgt;
                    end
                end
                FETCH: begin
                    if (bus_done) begin
                        if (x_jump_i) begin
                            pc <= jump_tgt;
                        end else if (bus_err) begin
                            f_ack_o <= 1'b1;
                            f_pc_o  <= pc;
                        end else begin
                            f_ack_o <= 1'b1;
                            f_dat_o <= bus.i_dat_i;
                            f_pc_o  <= pc;
                            pc      <= pc + XLEN'(4);
                        end
                    end else if (x_jump_i) begin
                        pend <= jump_tgt;
                    end
                end
                SQUASH: begin
                    if (bus_done) begin
                        pc <= x_jump_i ? jump_tgt : pend;
                    end else if (x_jump_i) begin
                        pend <= jump_tgt;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

`ifdef POLARIS_FETCH_ERR_EN
    // Fault flag for decode and the halt latch that parks fetch after an error.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            f_err_o <= 1'b0;
            halted  <= 1'b0;
        end else begin
            f_err_o <= (state == FETCH) && bus_err && !x_jump_i;
            if ((state == FETCH) && bus_err && !x_jump_i) begin
                halted <= 1'b1;
            end else if ((state == IDLE) && x_jump_i) begin
                halted <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_f.sv
// Self-checking bench for stage_f. A memory responder with configurable wait
// states drives the bus; a transaction-level reference model predicts which
// words reach decode and where the next bus cycle must start.
// Exercises the bus-error path when POLARIS_FETCH_ERR_EN is defined.
module tb_stage_f;
    import polaris_pkg::*;

    localparam logic [63:0] RPC = 64'h1000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        f_ack_o;
    logic [31:0] f_dat_o;
    logic [63:0] f_pc_o;
    logic        x_jump_i = 1'b0;
    logic [63:0] x_target_i = '0;
`ifdef POLARIS_FETCH_ERR_EN
    logic        f_err_o;
    logic        err_arm = 1'b0;
    logic [63:0] err_at = '0;
`endif

    stage_f_if bus();

    stage_f #(.RESET_PC(RPC)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .bus        (bus),
        .f_ack_o    (f_ack_o),
        .f_dat_o    (f_dat_o),
        .f_pc_o     (f_pc_o),
`ifdef POLARIS_FETCH_ERR_EN
        .f_err_o    (f_err_o),
`endif
        .x_jump_i   (x_jump_i),
        .x_target_i (x_target_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model state: memory timing and the current bus transaction.
    int          ws = 0;
    int          wcnt = 0;
    logic        rand_ws = 1'b0;
    logic        tr_active = 1'b0;
    logic [63:0] tr_adr = '0;
    logic        tr_jump = 1'b0;
    logic [63:0] tr_tgt = '0;
    logic [63:0] last_pc = '0;
    logic        halted_m = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return ((a[31:0] ^ a[63:32]) * 32'h9E3779B1) + 32'h1234_5677;
    endfunction

    // One clock of bus activity with model prediction and output checks.
    task automatic tick(input logic jmp, input logic [63:0] tgt);
        logic        was_cyc;
        logic        term;
        logic        err_now;
        logic        resume;
        logic        exp_ack;
        logic [31:0] exp_dat;
        logic        exp_err;
        @(negedge clk_i);
        was_cyc = bus.i_cyc_o;
        checks++;
        if (bus.i_stb_o !== was_cyc) begin
            failures++;
            $display("[TB] FAIL stb_eq_cyc: got %b expected %b", bus.i_stb_o, was_cyc);
        end
        if (halted_m) begin
            checks++;
            if (was_cyc !== 1'b0) begin
                failures++;
                $display("[TB] FAIL halt_idle: got cyc=%b expected 0", was_cyc);
            end
        end
        term = was_cyc && (wcnt >= ws);
        err_now = 1'b0;
`ifdef POLARIS_FETCH_ERR_EN
        if (term && err_arm && !jmp && bus.i_adr_o == err_at) err_now = 1'b1;
        bus.i_err_i = err_now;
`endif
        bus.i_ack_i = term && !err_now;
        bus.i_dat_i = mem_word(bus.i_adr_o);
        x_jump_i = jmp;
        x_target_i = tgt;
        if (was_cyc) begin
            if (!tr_active) begin
                tr_active = 1'b1;
                tr_adr = bus.i_adr_o;
                tr_jump = 1'b0;
            end else begin
                checks++;
                if (bus.i_adr_o !== tr_adr) begin
                    failures++;
                    $display("[TB] FAIL adr_stable: got %h expected %h", bus.i_adr_o, tr_adr);
                end
            end
            if (jmp) begin
                tr_jump = 1'b1;
                tr_tgt = tgt & 64'hFFFF_FFFF_FFFF_FFFC;
            end
        end
        resume = halted_m && jmp;
        @(posedge clk_i);
        #1;
        bus.i_ack_i = 1'b0;
`ifdef POLARIS_FETCH_ERR_EN
        bus.i_err_i = 1'b0;
`endif
        exp_ack = 1'b0;
        exp_dat = NOP;
        exp_err = 1'b0;
        if (term) begin
            wcnt = 0;
            if (rand_ws) ws = $urandom_range(0, 2);
            tr_active = 1'b0;
            checks++;
            if (tr_jump) begin
                if (bus.i_cyc_o !== 1'b1 || bus.i_adr_o !== tr_tgt) begin
                    failures++;
                    $display("[TB] FAIL redirect_adr: got cyc=%b adr=%h expected cyc=1 adr=%h",
                             bus.i_cyc_o, bus.i_adr_o, tr_tgt);
                end
            end else if (err_now) begin
                exp_ack = 1'b1;
                exp_err = 1'b1;
                last_pc = tr_adr;
                halted_m = 1'b1;
                if (bus.i_cyc_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL halt_cyc: got %b expected 0", bus.i_cyc_o);
                end
            end else begin
                exp_ack = 1'b1;
                exp_dat = mem_word(tr_adr);
                last_pc = tr_adr;
                if (bus.i_cyc_o !== 1'b1 || bus.i_adr_o !== tr_adr + 64'd4) begin
                    failures++;
                    $display("[TB] FAIL next_adr: got cyc=%b adr=%h expected cyc=1 adr=%h",
                             bus.i_cyc_o, bus.i_adr_o, tr_adr + 64'd4);
                end
            end
        end else if (was_cyc) begin
            wcnt++;
        end
        if (resume) begin
            halted_m = 1'b0;
            checks++;
            if (bus.i_cyc_o !== 1'b1 || bus.i_adr_o !== (tgt & 64'hFFFF_FFFF_FFFF_FFFC)) begin
                failures++;
                $display("[TB] FAIL resume_adr: got cyc=%b adr=%h expected cyc=1 adr=%h",
                         bus.i_cyc_o, bus.i_adr_o, tgt & 64'hFFFF_FFFF_FFFF_FFFC);
            end
        end
        checks++;
        if (f_ack_o !== exp_ack) begin
            failures++;
            $display("[TB] FAIL f_ack: got %b expected %b", f_ack_o, exp_ack);
        end
        checks++;
        if (f_dat_o !== exp_dat) begin
            failures++;
            $display("[TB] FAIL f_dat: got %h expected %h", f_dat_o, exp_dat);
        end
        checks++;
        if (f_pc_o !== last_pc) begin
            failures++;
            $display("[TB] FAIL f_pc: got %h expected %h", f_pc_o, last_pc);
        end
`ifdef POLARIS_FETCH_ERR_EN
        checks++;
        if (f_err_o !== exp_err) begin
            failures++;
            $display("[TB] FAIL f_err: got %b expected %b", f_err_o, exp_err);
        end
`endif
    endtask

    // Assert reset away from a clock edge and check that outputs clear at once.
    task automatic apply_reset();
        @(negedge clk_i);
        #2;
        reset_i = 1'b0;
        x_jump_i = 1'b0;
        bus.i_ack_i = 1'b0;
        #1;
        checks++;
        if (bus.i_cyc_o !== 1'b0 || bus.i_stb_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_cyc: got cyc=%b stb=%b expected 0", bus.i_cyc_o, bus.i_stb_o);
        end
        checks++;
        if (f_ack_o !== 1'b0 || f_dat_o !== NOP || f_pc_o !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_f: got ack=%b dat=%h pc=%h expected 0/%h/0",
                     f_ack_o, f_dat_o, f_pc_o, NOP);
        end
        checks++;
        if (bus.i_adr_o !== RPC) begin
            failures++;
            $display("[TB] FAIL reset_adr: got %h expected %h", bus.i_adr_o, RPC);
        end
`ifdef POLARIS_FETCH_ERR_EN
        checks++;
        if (f_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err: got %b expected 0", f_err_o);
        end
`endif
        repeat (2) @(posedge clk_i);
        tr_active = 1'b0;
        wcnt = 0;
        halted_m = 1'b0;
        last_pc = '0;
    endtask

    // Release reset; optionally present a stale ack while still in IDLE.
    task automatic release_reset(input logic late_ack);
        @(negedge clk_i);
        reset_i = 1'b1;
        bus.i_ack_i = late_ack;
        bus.i_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.i_cyc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_release: got cyc=%b expected 0", bus.i_cyc_o);
        end
        @(posedge clk_i);
        #1;
        bus.i_ack_i = 1'b0;
        checks++;
        if (bus.i_cyc_o !== 1'b1 || bus.i_adr_o !== RPC || f_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_strobe: got cyc=%b adr=%h ack=%b expected 1/%h/0",
                     bus.i_cyc_o, bus.i_adr_o, f_ack_o, RPC);
        end
    endtask

    // Advance until a word has just been presented (bounded).
    task automatic wait_boundary();
        int n;
        n = 0;
        tick(1'b0, '0);
        while (!f_ack_o && n < 12) begin
            tick(1'b0, '0);
            n++;
        end
        checks++;
        if (f_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL boundary_timeout: got f_ack=%b expected 1", f_ack_o);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        release_reset(1'b0);
    endtask

    task automatic test_stream();
        ws = 0;
        tick(1'b0, '0);
        checks++;
        if (bus.i_adr_o !== 64'h1004 || f_dat_o !== mem_word(64'h1000) || f_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream_1000: got adr=%h dat=%h ack=%b expected 1004/%h/1",
                     bus.i_adr_o, f_dat_o, f_ack_o, mem_word(64'h1000));
        end
        tick(1'b0, '0);
        checks++;
        if (bus.i_adr_o !== 64'h1008 || f_dat_o !== mem_word(64'h1004) || f_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream_1004: got adr=%h dat=%h ack=%b expected 1008/%h/1",
                     bus.i_adr_o, f_dat_o, f_ack_o, mem_word(64'h1004));
        end
    endtask

    task automatic test_jump_on_ack();
        tick(1'b1, 64'h2003);
        checks++;
        if (bus.i_adr_o !== 64'h2000 || f_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_on_ack: got adr=%h ack=%b expected 2000/0", bus.i_adr_o, f_ack_o);
        end
        tick(1'b0, '0);
        checks++;
        if (f_pc_o !== 64'h2000 || f_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL after_jump: got pc=%h ack=%b expected 2000/1", f_pc_o, f_ack_o);
        end
    endtask

    task automatic test_wait_states();
        int pulses;
        ws = 2;
        repeat (3) tick(1'b0, '0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, '0);
            if (f_ack_o) pulses++;
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("[TB] FAIL wait_pulses: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_squash();
        ws = 2;
        wait_boundary();
        tick(1'b1, 64'h3000);
        tick(1'b1, 64'h4000);
        tick(1'b0, '0);
        checks++;
        if (bus.i_adr_o !== 64'h4000 || f_ack_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL squash_adr: got adr=%h ack=%b expected 4000/0", bus.i_adr_o, f_ack_o);
        end
        repeat (3) tick(1'b0, '0);
        checks++;
        if (f_pc_o !== 64'h4000 || f_ack_o !== 1'b1 || f_dat_o !== mem_word(64'h4000)) begin
            failures++;
            $display("[TB] FAIL squash_resume: got pc=%h ack=%b dat=%h expected 4000/1/%h",
                     f_pc_o, f_ack_o, f_dat_o, mem_word(64'h4000));
        end
    endtask

    task automatic test_wrap();
        ws = 0;
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(1'b0, '0);
        checks++;
        if (bus.i_adr_o !== 64'h0 || f_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++;
            $display("[TB] FAIL pc_wrap: got adr=%h pc=%h expected 0/fffffffffffffffc",
                     bus.i_adr_o, f_pc_o);
        end
    endtask

    task automatic test_random();
        logic        jmp;
        logic [63:0] tgt;
        rand_ws = 1'b1;
        for (int i = 0; i < 400; i++) begin
            jmp = bus.i_cyc_o && ($urandom_range(0, 4) == 0);
            tgt = {$urandom, $urandom};
            tick(jmp, tgt);
        end
        rand_ws = 1'b0;
    endtask

    task automatic test_reset_mid();
        ws = 2;
        wait_boundary();
        tick(1'b0, '0);
        apply_reset();
        release_reset(1'b1);
        ws = 0;
        tick(1'b0, '0);
        checks++;
        if (f_pc_o !== RPC || f_dat_o !== mem_word(RPC)) begin
            failures++;
            $display("[TB] FAIL restart: got pc=%h dat=%h expected %h/%h",
                     f_pc_o, f_dat_o, RPC, mem_word(RPC));
        end
    endtask

`ifdef POLARIS_FETCH_ERR_EN
    task automatic test_bus_error();
        apply_reset();
        release_reset(1'b0);
        ws = 0;
        err_arm = 1'b1;
        err_at = 64'h1004;
        tick(1'b0, '0);
        tick(1'b0, '0);
        checks++;
        if (f_err_o !== 1'b1 || f_pc_o !== 64'h1004 || f_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fault_report: got err=%b pc=%h ack=%b expected 1/1004/1",
                     f_err_o, f_pc_o, f_ack_o);
        end
        repeat (3) tick(1'b0, '0);
        checks++;
        if (f_err_o !== 1'b0 || bus.i_cyc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fault_halt: got err=%b cyc=%b expected 0/0", f_err_o, bus.i_cyc_o);
        end
        err_arm = 1'b0;
        tick(1'b1, 64'h5000);
        checks++;
        if (bus.i_adr_o !== 64'h5000 || bus.i_cyc_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fault_resume: got adr=%h cyc=%b expected 5000/1", bus.i_adr_o, bus.i_cyc_o);
        end
        tick(1'b0, '0);
        checks++;
        if (f_pc_o !== 64'h5000 || f_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fault_fetch: got pc=%h ack=%b expected 5000/1", f_pc_o, f_ack_o);
        end
    endtask
`endif

    initial begin
        bus.i_ack_i = 1'b0;
        bus.i_dat_i = '0;
`ifdef POLARIS_FETCH_ERR_EN
        bus.i_err_i = 1'b0;
`endif
        $display("[TB] stage_f bench start");
        test_reset();
        test_stream();
        test_jump_on_ack();
        test_wait_states();
        test_squash();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef POLARIS_FETCH_ERR_EN
        test_bus_error();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
